// File: rtl/y86_pipe_reg_if.sv
// Control and payload bundle between the hazard unit / upstream stage and a y86_pipe_reg instance.
// master drives payload and control; slave is the pipeline register itself.
interface y86_pipe_reg_if #(
    parameter int WIDTH = 144
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic             perf_clr;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             ctl_err;
    logic [31:0]      stall_cnt;
    logic [31:0]      bubble_cnt;

    modport master (
        output in_data, in_valid, stall, bubble, flush, perf_clr,
        input  out_data, out_valid, ctl_err, stall_cnt, bubble_cnt
    );

    modport slave (
        input  in_data, in_valid, stall, bubble, flush, perf_clr,
        output out_data, out_valid, ctl_err, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/y86_pipe_reg.sv
// Generic Y86-64 pipeline register: DEPTH stages of payload+valid with normal/stall/bubble/flush control.
// Latency DEPTH cycles; stall holds every stage (no data lost), flush overrides stall and bubble.
// Optional perf counters (stall/bubble cycles, saturating) built only when Y86_PIPE_REG_PERF_EN is defined.
module y86_pipe_reg #(
    parameter int               WIDTH       = 144,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] BUBBLE_WORD = 144'h22_00000000000000000000000000000000_FF
) (
    input  logic           clk,
    input  logic           rst_n,
    y86_pipe_reg_if.slave  bus
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic             ctl_err_q;
    logic             ctl_err_d;

    always_comb begin
        data_d    = data_q;
        vld_d     = vld_q;
        ctl_err_d = ctl_err_q;
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = BUBBLE_WORD;
            end
            vld_d = '0;
        end else if (bus.stall) begin
            // Stall wins over a simultaneous bubble; the conflict is latched for debug.
            if (bus.bubble) begin
                ctl_err_d = 1'b1;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            if (bus.bubble) begin
                data_d[0] = BUBBLE_WORD;
                vld_d[0]  = 1'b0;
            end else begin
                data_d[0] = bus.in_data;
                vld_d[0]  = bus.in_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= BUBBLE_WORD;
            end
            vld_q     <= '0;
            ctl_err_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            vld_q     <= vld_d;
            ctl_err_q <= ctl_err_d;
        end
    end

    assign bus.out_data  = data_q[DEPTH-1];
    assign bus.out_valid = vld_q[DEPTH-1];
    assign bus.ctl_err   = ctl_err_q;

`ifdef Y86_PIPE_REG_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;
    logic        stall_inc;
    logic        bubble_inc;

    assign stall_inc  = bus.stall & ~bus.flush;
    assign bubble_inc = bus.bubble & ~bus.stall & ~bus.flush;

    // Clear beats increment; both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.perf_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (bubble_inc && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;
`else
    logic unused_perf_clr;

    assign unused_perf_clr = bus.perf_clr;
    assign bus.stall_cnt   = '0;
    assign bus.bubble_cnt  = '0;
`endif

endmodule

// File: tb/tb_y86_pipe_reg.sv
// Bench for y86_pipe_reg: four instances (DEPTH 1..4) share one stimulus stream.
// DEPTH=1 vector table, a queue scoreboard for every depth, and hand-written corner sequences.
module tb_y86_pipe_reg;
    localparam int W = 144;
    localparam logic [W-1:0] BW = 144'h22_00000000000000000000000000000000_FF;
`ifdef Y86_PIPE_REG_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         valid;
    } entry_t;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
        logic         st;
        logic         bb;
        logic         fl;
        logic [W-1:0] ed;
        logic         ev;
    } vec_t;

    localparam entry_t BWE = '{data: BW, valid: 1'b0};

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         stall;
    logic         bubble;
    logic         flush;
    logic         perf_clr;

    int checks;
    int errors;

    entry_t q1[$];
    entry_t q2[$];
    entry_t q3[$];
    entry_t q4[$];

    y86_pipe_reg_if #(.WIDTH(W)) if1 ();
    y86_pipe_reg_if #(.WIDTH(W)) if2 ();
    y86_pipe_reg_if #(.WIDTH(W)) if3 ();
    y86_pipe_reg_if #(.WIDTH(W)) if4 ();

    assign if1.in_data = in_data; assign if1.in_valid = in_valid; assign if1.stall = stall;
    assign if1.bubble = bubble;   assign if1.flush = flush;       assign if1.perf_clr = perf_clr;
    assign if2.in_data = in_data; assign if2.in_valid = in_valid; assign if2.stall = stall;
    assign if2.bubble = bubble;   assign if2.flush = flush;       assign if2.perf_clr = perf_clr;
    assign if3.in_data = in_data; assign if3.in_valid = in_valid; assign if3.stall = stall;
    assign if3.bubble = bubble;   assign if3.flush = flush;       assign if3.perf_clr = perf_clr;
    assign if4.in_data = in_data; assign if4.in_valid = in_valid; assign if4.stall = stall;
    assign if4.bubble = bubble;   assign if4.flush = flush;       assign if4.perf_clr = perf_clr;

    y86_pipe_reg #(.WIDTH(W), .DEPTH(1), .BUBBLE_WORD(BW)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    y86_pipe_reg #(.WIDTH(W), .DEPTH(2), .BUBBLE_WORD(BW)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    y86_pipe_reg #(.WIDTH(W), .DEPTH(3), .BUBBLE_WORD(BW)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    y86_pipe_reg #(.WIDTH(W), .DEPTH(4), .BUBBLE_WORD(BW)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
        return {3'd1, ic, 1'b1, ve, va, 4'h3, 4'h5};
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Expected stage contents, oldest first: q[0] is what the last stage must present.
    task automatic adv(inout entry_t q[$], input entry_t e, input logic hold, input logic fl);
        entry_t tmp;
        if (fl) begin
            foreach (q[i]) q[i] = BWE;
        end else if (!hold) begin
            tmp = q.pop_front();
            q.push_back(e);
        end
    endtask

    task automatic step(input logic [W-1:0] d, input logic v, input logic st, input logic bb, input logic fl);
        entry_t e;
        in_data  = d;
        in_valid = v;
        stall    = st;
        bubble   = bb;
        flush    = fl;
        e = bb ? BWE : '{data: d, valid: v};
        @(posedge clk);
        #1;
        adv(q1, e, st, fl);
        adv(q2, e, st, fl);
        adv(q3, e, st, fl);
        adv(q4, e, st, fl);
        chk("sb_d1_data", if1.out_data, q1[0].data);  chk("sb_d1_valid", W'(if1.out_valid), W'(q1[0].valid));
        chk("sb_d2_data", if2.out_data, q2[0].data);  chk("sb_d2_valid", W'(if2.out_valid), W'(q2[0].valid));
        chk("sb_d3_data", if3.out_data, q3[0].data);  chk("sb_d3_valid", W'(if3.out_valid), W'(q3[0].valid));
        chk("sb_d4_data", if4.out_data, q4[0].data);  chk("sb_d4_valid", W'(if4.out_valid), W'(q4[0].valid));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t tbl [10];
        logic [W-1:0] a, b, c, d, e, f, g, z;

        checks = 0;
        errors = 0;
        a = mk(4'd6, 64'h10, 64'h1);
        b = mk(4'd2, 64'h2222, 64'h2);
        c = mk(4'd3, 64'h3333_0000, 64'h3);
        d = mk(4'd5, 64'hDEAD_BEEF, 64'h4);
        e = mk(4'd7, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF);
        f = mk(4'd8, 64'h6, 64'h6);
        g = mk(4'd9, 64'h7, 64'h7);
        z = mk(4'd0, 64'h0, 64'h0);

        tbl[0] = '{a, 1'b1, 1'b0, 1'b0, 1'b0, a,  1'b1};
        tbl[1] = '{b, 1'b0, 1'b0, 1'b0, 1'b0, b,  1'b0};
        tbl[2] = '{c, 1'b1, 1'b1, 1'b0, 1'b0, b,  1'b0};
        tbl[3] = '{c, 1'b1, 1'b0, 1'b0, 1'b0, c,  1'b1};
        tbl[4] = '{d, 1'b1, 1'b0, 1'b1, 1'b0, BW, 1'b0};
        tbl[5] = '{d, 1'b1, 1'b0, 1'b0, 1'b0, d,  1'b1};
        tbl[6] = '{e, 1'b1, 1'b1, 1'b0, 1'b1, BW, 1'b0};
        tbl[7] = '{e, 1'b1, 1'b0, 1'b0, 1'b0, e,  1'b1};
        tbl[8] = '{f, 1'b1, 1'b0, 1'b1, 1'b1, BW, 1'b0};
        tbl[9] = '{f, 1'b0, 1'b0, 1'b0, 1'b0, f,  1'b0};

        for (int i = 0; i < 1; i++) q1.push_back(BWE);
        for (int i = 0; i < 2; i++) q2.push_back(BWE);
        for (int i = 0; i < 3; i++) q3.push_back(BWE);
        for (int i = 0; i < 4; i++) q4.push_back(BWE);

        // Reset held with live inputs: outputs must stay at the bubble word.
        rst_n = 1'b0; in_data = a; in_valid = 1'b1; stall = 1'b0; bubble = 1'b0; flush = 1'b0; perf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d1_data", if1.out_data, BW);  chk("rst_d1_valid", W'(if1.out_valid), '0);
        chk("rst_d4_data", if4.out_data, BW);  chk("rst_d4_valid", W'(if4.out_valid), '0);
        chk("rst_ctl_err", W'(if3.ctl_err), '0);
        chk("rst_stall_cnt", W'(if2.stall_cnt), '0);
        chk("rst_bubble_cnt", W'(if2.bubble_cnt), '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            in_data = tbl[i].d; in_valid = tbl[i].v; stall = tbl[i].st; bubble = tbl[i].bb; flush = tbl[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_data", i), if1.out_data, tbl[i].ed);
            chk($sformatf("tbl%0d_valid", i), W'(if1.out_valid), W'(tbl[i].ev));
        end
        chk("tbl_ctl_err_d1", W'(if1.ctl_err), '0);
        chk("tbl_ctl_err_d4", W'(if4.ctl_err), '0);

        // Resynchronise the scoreboard with a flush.
        step(z, 1'b0, 1'b0, 1'b0, 1'b1);

        // Stall hold on DEPTH=3.
        perf_clr = 1'b1;
        step(a, 1'b1, 1'b0, 1'b0, 1'b0);
        perf_clr = 1'b0;
        step(b, 1'b1, 1'b0, 1'b0, 1'b0);
        step(c, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_pre_d3", if3.out_data, a);
        step(d, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("stall_hold1_d3", if3.out_data, a);
        step(d, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("stall_hold2_d3", if3.out_data, a);
        chk("stall_cnt_d3", W'(if3.stall_cnt), PERF ? W'(2) : W'(0));
        step(d, 1'b1, 1'b0, 1'b0, 1'b0);
        step(z, 1'b0, 1'b0, 1'b0, 1'b0);
        step(z, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_d_out_d3", if3.out_data, d);
        chk("stall_d_valid_d3", W'(if3.out_valid), W'(1));

        // Bubble injection on DEPTH=2.
        perf_clr = 1'b1;
        step(a, 1'b1, 1'b0, 1'b0, 1'b0);
        perf_clr = 1'b0;
        step(z, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("bub_a_d2", if2.out_data, a);       chk("bub_a_valid_d2", W'(if2.out_valid), W'(1));
        step(b, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bub_bw_d2", if2.out_data, BW);     chk("bub_bw_valid_d2", W'(if2.out_valid), W'(0));
        step(e, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bub_b_d2", if2.out_data, b);       chk("bub_b_valid_d2", W'(if2.out_valid), W'(1));
        chk("bubble_cnt_d2", W'(if2.bubble_cnt), PERF ? W'(1) : W'(0));

        // Flush beats stall on DEPTH=4.
        perf_clr = 1'b1;
        step(a, 1'b1, 1'b0, 1'b0, 1'b0);
        perf_clr = 1'b0;
        step(b, 1'b1, 1'b0, 1'b0, 1'b0);
        step(c, 1'b1, 1'b0, 1'b0, 1'b0);
        step(d, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fill_d4", if4.out_data, a);
        step(e, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("flush_d4", if4.out_data, BW);      chk("flush_valid_d4", W'(if4.out_valid), W'(0));
        chk("flush_ctl_err_d4", W'(if4.ctl_err), '0);
        chk("flush_stall_cnt_d4", W'(if4.stall_cnt), '0);
        repeat (3) step(f, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_all_d4", if4.out_data, BW);
        step(f, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stall+bubble conflict, then asynchronous reset mid-cycle.
        step(g, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("conf_ctl_err_d4", W'(if4.ctl_err), W'(1));
        chk("conf_hold_d4", if4.out_data, f);
        chk("conf_ctl_err_d1", W'(if1.ctl_err), W'(1));
        step(g, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("conf_sticky_d4", W'(if4.ctl_err), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data_d4", if4.out_data, BW);  chk("arst_valid_d4", W'(if4.out_valid), '0);
        chk("arst_ctl_err_d4", W'(if4.ctl_err), '0);
        chk("arst_data_d1", if1.out_data, BW);
        adv(q1, BWE, 1'b0, 1'b1);
        adv(q2, BWE, 1'b0, 1'b1);
        adv(q3, BWE, 1'b0, 1'b1);
        adv(q4, BWE, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step(a, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_ctl_err", W'(if2.ctl_err), '0);

`ifdef Y86_PIPE_REG_PERF_EN
        // Saturation: preload near the top, then stall past it.
        @(negedge clk);
        force u_d3.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release u_d3.stall_cnt_q;
        repeat (3) step(b, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_stall_cnt_d3", W'(if3.stall_cnt), W'(32'hFFFF_FFFF));
        perf_clr = 1'b1;
        step(b, 1'b1, 1'b1, 1'b0, 1'b0);
        perf_clr = 1'b0;
        chk("clr_stall_cnt_d3", W'(if3.stall_cnt), '0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/y86_pipe_reg.md
Name: y86_pipe_reg

Overview:
- Generic, parametrised pipeline register for the Y86-64 pipeline. Replaces the per-stage fixed-field registers (F/D/E/M/W).
- Carries a packed payload through DEPTH clocked stages.
- Implements the pipeline-control actions normal, stall, bubble and flush, plus a valid tag per stage.
- Sits between two pipeline stages. Driven by the hazard/pipeline-control unit.

Parameters:
- WIDTH, 144, payload width in bits. Default = M-stage packing: stat[143:141], icode[140:137], Cnd[136], valE[135:72], valA[71:8], dstE[7:4], dstM[3:0].
- DEPTH, 1, number of register stages in the chain. Legal range 1..4.
- BUBBLE_WORD, 144'h22_00000000000000000000000000000000_FF, payload loaded on bubble, flush or reset. Decodes as stat=SAOK(1), icode=INOP(1), Cnd=0, valE=0, valA=0, dstE=dstM=RNONE(F).

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  payload from the upstream stage
- in_valid  input  1  upstream payload is a real instruction
- stall  input  1  hold all stages
- bubble  input  1  inject BUBBLE_WORD into stage 0
- flush  input  1  load BUBBLE_WORD into every stage
- out_data  output  WIDTH  payload of the last stage
- out_valid  output  1  valid tag of the last stage
- ctl_err  output  1  sticky: stall and bubble were asserted in the same cycle
- perf_clr  input  1  synchronous clear of the performance counters (feature-gated)
- stall_cnt  output  32  stall-cycle counter (feature-gated)
- bubble_cnt  output  32  bubble-cycle counter (feature-gated)

Behaviour:
- Reset: rst_n low asynchronously sets every stage data to BUBBLE_WORD, every valid tag to 0, ctl_err=0, and both counters to 0. Release is synchronous to clk; the first capture happens on the first rising edge with rst_n high.
- Storage: stage[0..DEPTH-1]; out_data=stage[DEPTH-1].data and out_valid=stage[DEPTH-1].valid, both registered with no combinational path from the inputs.
- Latency: DEPTH cycles from in_data to out_data when no stall or bubble is applied.
- Per rising edge, the first matching rule applies:
  1. flush=1: all stages load BUBBLE_WORD with valid=0. Overrides stall and bubble.
  2. stall=1: all stages hold. If bubble=1 in the same cycle, stall still wins, bubble is ignored and ctl_err sets to 1.
  3. bubble=1: stage[0] loads BUBBLE_WORD with valid=0; stage[i] loads stage[i-1] for i≥1.
  4. Otherwise: stage[0] loads in_data with in_valid; stage[i] loads stage[i-1].
- ctl_err clears only on reset.
- in_valid=0 with no control asserted: in_data is still captured and propagated. Consumers qualify with out_valid.
- DEPTH=1: rules 3 and 4 affect only stage[0].
- rst_n asserted mid-stall or mid-flush: reset wins immediately; no pending action survives.
- The block has no internal FSM beyond the stage registers and the sticky flag.

Optional Feature:
- Macro: Y86_PIPE_REG_PERF_EN.
- Defined:
  - stall_cnt increments on every edge where stall=1 and flush=0.
  - bubble_cnt increments on every edge where rule 3 applies.
  - Both counters are 32-bit and saturate at 32'hFFFFFFFF with no wrap.
  - perf_clr=1 zeroes both counters at the next edge and takes priority over an increment in the same cycle.
- Undefined: no counter flops are built; stall_cnt and bubble_cnt are tied to 0 and perf_clr is ignored.

Test Plan:
- Pass-through, DEPTH=1: after reset, drive in_data=icode 6/valE=0x10, in_valid=1 -> out_data equals in_data and out_valid=1 one cycle later; during reset out_data=BUBBLE_WORD and out_valid=0.
- Stall hold, DEPTH=3: stream payloads A,B,C, then stall for 2 cycles while driving D -> out_data stays fixed for 2 cycles; after release, D emerges 3 cycles later; stall_cnt=2.
- Bubble injection, DEPTH=2: stream A, bubble for 1 cycle, then B -> output sequence A, BUBBLE_WORD (out_valid=0), B; bubble_cnt=1.
- Flush beats stall: fill DEPTH=4 with valid data, assert flush and stall together -> next cycle every stage is BUBBLE_WORD, out_valid=0, ctl_err stays 0.
- Conflict plus async reset: stall=bubble=1 for one cycle -> ctl_err=1 and stages held. Then pull rst_n low mid-cycle -> out_data=BUBBLE_WORD and ctl_err=0 immediately, without waiting for a clock edge.
- Counter saturation (with Y86_PIPE_REG_PERF_EN): force stall_cnt to 32'hFFFFFFFE, stall for 3 cycles -> stall_cnt=32'hFFFFFFFF. Then apply perf_clr together with stall -> stall_cnt=0.
